dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder for the pipeline's data-memory port (memory-stage address, write data, write strobe; read data returned to the memory/writeback register).
- Word-addressed flop-based RAM with combinational read and synchronous write.
- Sticky alignment/range fault tracking.
- Optional memory-mapped I/O page: cycle counter, console output register, fault registers.

Parameters:
- DEPTH, 64, number of 32-bit RAM words; must be a power of two, at least 4.
- AW, 6, word-index width; must equal log2(DEPTH).
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 16-byte I/O page. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  write strobe from the memory stage.
- ALUOutM  input  32  byte address from the memory stage.
- WriteDataM  input  32  store data.
- DmmRD  output  32  read data, combinational from ALUOutM.
- console_valid  output  1  one-cycle pulse, high in the cycle after a console write.
- console_data  output  32  last value written to the console register.
- fault  output  1  sticky error flag.
- fault_addr  output  32  byte address of the most recent faulting write.

Behaviour:
- Reset (sync, active high) clears:
  - all RAM words,
  - cycle counter,
  - console_valid and console_data,
  - fault and fault_addr.
- Reset overrides any write presented in the same cycle.
- Address decode, byte address A = ALUOutM:
  - RAM hit: A < DEPTH*4. Word index is A[AW+1:2].
  - MMIO hit: A[31:4] == MMIO_BASE[31:4]. Register selected by A[3:2].
  - Otherwise: unmapped.
- Read (no strobe; always active):
  - DmmRD = RAM[index] on a RAM hit.
  - DmmRD = the selected MMIO register on an MMIO hit.
  - DmmRD = 0 when unmapped.
  - Reads ignore A[1:0].
- Write (MemWriteM=1), committed at the rising edge:
  - Legal write: A[1:0]==0 and A is RAM or MMIO.
    - RAM: RAM[index] <= WriteDataM.
  - Illegal write: A[1:0]!=0, or A unmapped.
    - Write suppressed.
    - fault <= 1, fault_addr <= A.
- Read-during-write to the same word returns the old value; the new value is visible from the next cycle.
- MMIO registers (word offsets):
  - 0x0 CYCLE, read-only.
    - Free-running 32-bit counter, +1 every cycle after reset.
    - Wraps FFFF_FFFF -> 0.
    - Writes are ignored and do not fault.
  - 0x4 CONSOLE, write-only; reads return console_data.
    - A write sets console_data <= WriteDataM.
    - console_valid = 1 for exactly the following cycle.
    - Back-to-back writes give console_valid high on consecutive cycles, each with the new data.
  - 0x8 FAULT, read {31'b0, fault}.
    - Any legal write clears fault. fault_addr is retained.
    - A new fault in the same cycle as a clear: the fault wins (fault stays 1, fault_addr updated).
  - 0xC FAULT_ADDR, read-only. Writes are ignored.
- Timing:
  - Read latency is 0 cycles; the pipeline captures DmmRD at the same edge the address is valid.
  - Write latency is 1 edge.
  - No handshake or back-pressure: every request completes in its cycle.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - MMIO page decoded as above.
  - Cycle counter and console logic present.
- Undefined:
  - No MMIO decode; MMIO_BASE addresses are treated as unmapped (read 0, writes fault).
  - console_valid and console_data tied to 0.
  - No cycle counter registers.
  - fault and fault_addr behave the same as with the feature.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to 0x0000_0010 with MemWriteM=1. In the same cycle DmmRD = 0 (old value). After the edge, reading 0x10 gives DEAD_BEEF and reading 0x13 also gives DEAD_BEEF.
- Write 0x1234_5678 to 0x0000_0006 (misaligned), then write 0x1 to 0x0000_0400 (unmapped, DEPTH=64):
  - RAM word 1 unchanged.
  - fault=1 after the first edge; fault_addr = 0x0000_0400 after the second edge.
  - Reading 0x400 gives 0.
- [DMEM_MMIO_EN] Write 0x41 to 0xFFFF_0004, then 0x42 on the next cycle: console_valid is high for 2 consecutive cycles with console_data 0x41 then 0x42, then low.
- [DMEM_MMIO_EN] Hold reset for 3 cycles, release, read 0xFFFF_0000 on the 10th cycle after release: value 9. Force the counter to FFFF_FFFF: the next read gives 0.
- [DMEM_MMIO_EN] With fault=1, write to 0xFFFF_0008 in the same cycle as the misaligned address 0xFFFF_0009:
  - Only one request per cycle is possible, so run the two orders instead.
  - Clear then fault: fault ends at 1.
  - Fault then clear: fault ends at 0 and fault_addr holds 0xFFFF_0009.
- Assert reset mid-sequence while MemWriteM=1 to 0x20: RAM[8] reads 0, fault=0 and console_valid=0 on the cycle after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory port responder for the pipeline memory stage.
// Word-addressed flop RAM (combinational read, synchronous write), sticky
// fault tracking for misaligned or unmapped writes, and an optional 16-byte
// memory-mapped I/O page enabled by defining DMEM_MMIO_EN.
//
// MMIO page (word offsets from MMIO_BASE), only with DMEM_MMIO_EN:
//   0x0 CYCLE      | free-running cycle counter, read-only
//   0x4 CONSOLE    | write sets console_data and pulses console_valid
//   0x8 FAULT      | reads {31'b0, fault}; any legal write clears fault
//   0xC FAULT_ADDR | reads fault_addr, read-only
//
// DEPTH must be a power of two (>= 4) and AW must equal log2(DEPTH).

module dmem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] DmmRD,
  output logic        console_valid,
  output logic [31:0] console_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] RamBytes = 32'(DEPTH * 4);

  localparam logic [1:0] RegCycle     = 2'd0;
  localparam logic [1:0] RegConsole   = 2'd1;
  localparam logic [1:0] RegFault     = 2'd2;
  localparam logic [1:0] RegFaultAddr = 2'd3;

  logic [31:0] mem [DEPTH];

  logic          ramHit;
  logic          mmioHit;
  logic          isAligned;
  logic          writeOk;
  logic          writeBad;
  logic          faultClear;
  logic [AW-1:0] wordIdx;
  logic [1:0]    regSel;

  assign ramHit    = (ALUOutM < RamBytes);
  assign isAligned = (ALUOutM[1:0] == 2'b00);
  assign wordIdx   = ALUOutM[AW+1:2];
  assign regSel    = ALUOutM[3:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] cycleCnt;
  logic        consoleWr;

  assign mmioHit    = (ALUOutM[31:4] == MMIO_BASE[31:4]);
  assign consoleWr  = writeOk && mmioHit && (regSel == RegConsole);
  assign faultClear = writeOk && mmioHit && (regSel == RegFault);

  // Free-running cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) cycleCnt <= '0;
    else       cycleCnt <= cycleCnt + 32'd1;
  end

  // Console register and its one-cycle valid pulse following each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      console_valid <= 1'b0;
      console_data  <= '0;
    end else begin
      console_valid <= consoleWr;
      if (consoleWr) console_data <= WriteDataM;
    end
  end
`else
  assign mmioHit       = 1'b0;
  assign faultClear    = 1'b0;
  assign console_valid = 1'b0;
  assign console_data  = '0;
`endif

  // A write is legal only when word-aligned and landing in a mapped region.
  assign writeOk  = MemWriteM && isAligned && (ramHit || mmioHit);
  assign writeBad = MemWriteM && !(isAligned && (ramHit || mmioHit));

  // Combinational read path; the pipeline samples it at the same edge.
  always_comb begin
    DmmRD = '0;
    if (ramHit) begin
      DmmRD = mem[wordIdx];
    end else if (mmioHit) begin
`ifdef DMEM_MMIO_EN
      case (regSel)
        RegCycle:     DmmRD = cycleCnt;
        RegConsole:   DmmRD = console_data;
        RegFault:     DmmRD = {31'b0, fault};
        RegFaultAddr: DmmRD = fault_addr;
        default:      DmmRD = '0;
      endcase
`endif
    end
  end

  // RAM write port; reset clears every word and beats a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (writeOk && ramHit) begin
      mem[wordIdx] <= WriteDataM;
    end
  end

  // Sticky fault; a new fault takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (writeBad) begin
      fault      <= 1'b1;
      fault_addr <= ALUOutM;
    end else if (faultClear) begin
      fault      <= 1'b0;
    end
  end

endmodule
